// File: rtl/fw_wishbone_sram_arb_2x1.sv
// Two-initiator Wishbone classic arbiter in front of the single-port SRAM controller.
// Round-robin grant, one transfer per grant; payload and AMO tag pass through unchanged.
module fw_wishbone_sram_arb_2x1 #(
  parameter int unsigned ADR_WIDTH = 32,
  parameter int unsigned DAT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,

  input  logic [ADR_WIDTH-1:0]   t0_adr,
  input  logic [DAT_WIDTH-1:0]   t0_dat_w,
  output logic [DAT_WIDTH-1:0]   t0_dat_r,
  input  logic                   t0_cyc,
  input  logic                   t0_stb,
  input  logic                   t0_we,
  input  logic [DAT_WIDTH/8-1:0] t0_sel,
  input  logic [3:0]             t0_tgc,
  output logic                   t0_ack,

  input  logic [ADR_WIDTH-1:0]   t1_adr,
  input  logic [DAT_WIDTH-1:0]   t1_dat_w,
  output logic [DAT_WIDTH-1:0]   t1_dat_r,
  input  logic                   t1_cyc,
  input  logic                   t1_stb,
  input  logic                   t1_we,
  input  logic [DAT_WIDTH/8-1:0] t1_sel,
  input  logic [3:0]             t1_tgc,
  output logic                   t1_ack,

  output logic [ADR_WIDTH-1:0]   i_adr,
  output logic [DAT_WIDTH-1:0]   i_dat_w,
  output logic [DAT_WIDTH/8-1:0] i_sel,
  output logic [3:0]             i_tgc,
  output logic                   i_we,
  output logic                   i_cyc,
  output logic                   i_stb,
  input  logic [DAT_WIDTH-1:0]   i_dat_r,
  input  logic                   i_ack
);

  localparam int unsigned SEL_WIDTH = DAT_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last;
  logic   last_nxt;
  logic   req0;
  logic   req1;

  assign req0 = t0_cyc & t0_stb;
  assign req1 = t1_cyc & t1_stb;

  // State and round-robin pointer; last=1 lets port 0 win the first tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Next state: an ack hands over directly to a waiting peer, an abort falls back to IDLE.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_nxt = last ? GNT0 : GNT1;
        end else if (req0) begin
          state_nxt = GNT0;
        end else if (req1) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (i_ack) begin
          last_nxt  = 1'b0;
          state_nxt = req1 ? GNT1 : IDLE;
        end else if (!t0_cyc) begin
          state_nxt = IDLE;
        end
      end
      GNT1: begin
        if (i_ack) begin
          last_nxt  = 1'b1;
          state_nxt = req0 ? GNT0 : IDLE;
        end else if (!t1_cyc) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output mux; strobes and acks are also forced low by reset_n directly.
  always_comb begin
    i_adr   = t0_adr;
    i_dat_w = t0_dat_w;
    i_sel   = SEL_WIDTH'(t0_sel);
    i_we    = t0_we;
    i_tgc   = t0_tgc;
    i_cyc   = 1'b0;
    i_stb   = 1'b0;
    t0_ack  = 1'b0;
    t1_ack  = 1'b0;
    case (state)
      GNT0: begin
        i_cyc  = t0_cyc;
        i_stb  = t0_stb;
        t0_ack = i_ack;
      end
      GNT1: begin
        i_adr   = t1_adr;
        i_dat_w = t1_dat_w;
        i_sel   = SEL_WIDTH'(t1_sel);
        i_we    = t1_we;
        i_tgc   = t1_tgc;
        i_cyc   = t1_cyc;
        i_stb   = t1_stb;
        t1_ack  = i_ack;
      end
      default: ;
    endcase
    if (!reset_n) begin
      i_cyc  = 1'b0;
      i_stb  = 1'b0;
      t0_ack = 1'b0;
      t1_ack = 1'b0;
    end
  end

  assign t0_dat_r = i_dat_r;
  assign t1_dat_r = i_dat_r;

endmodule

// File: tb/tb_fw_wishbone_sram_arb_2x1.sv
// Bench for fw_wishbone_sram_arb_2x1: directed scenarios plus a random two-port run,
// with a small SRAM-controller stand-in downstream and a transaction-level memory model.
module tb_fw_wishbone_sram_arb_2x1;

  localparam int unsigned AW        = 32;
  localparam int unsigned DW        = 32;
  localparam int unsigned SW        = DW / 8;
  localparam int unsigned MEM_WORDS = 64;

  logic          clock;
  logic          reset_n;
  logic [AW-1:0] t0_adr, t1_adr, i_adr;
  logic [DW-1:0] t0_dat_w, t1_dat_w, t0_dat_r, t1_dat_r, i_dat_w, i_dat_r;
  logic          t0_cyc, t1_cyc, t0_stb, t1_stb, t0_we, t1_we, t0_ack, t1_ack;
  logic [SW-1:0] t0_sel, t1_sel, i_sel;
  logic [3:0]    t0_tgc, t1_tgc, i_tgc;
  logic          i_we, i_cyc, i_stb, i_ack;

  fw_wishbone_sram_arb_2x1 #(.ADR_WIDTH(AW), .DAT_WIDTH(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .t0_adr(t0_adr), .t0_dat_w(t0_dat_w), .t0_dat_r(t0_dat_r), .t0_cyc(t0_cyc),
    .t0_stb(t0_stb), .t0_we(t0_we), .t0_sel(t0_sel), .t0_tgc(t0_tgc), .t0_ack(t0_ack),
    .t1_adr(t1_adr), .t1_dat_w(t1_dat_w), .t1_dat_r(t1_dat_r), .t1_cyc(t1_cyc),
    .t1_stb(t1_stb), .t1_we(t1_we), .t1_sel(t1_sel), .t1_tgc(t1_tgc), .t1_ack(t1_ack),
    .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel), .i_tgc(i_tgc), .i_we(i_we),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_dat_r(i_dat_r), .i_ack(i_ack)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // SRAM controller stand-in: plain ack one cycle after strobe, AMO (tgc=1, add) one later.
  logic [31:0] mem [MEM_WORDS];
  logic        amo_wait;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      i_ack    <= 1'b0;
      amo_wait <= 1'b0;
      i_dat_r  <= '0;
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_word(i);
    end else if (i_ack) begin
      i_ack    <= 1'b0;
      amo_wait <= 1'b0;
    end else if (i_cyc && i_stb) begin
      if (i_tgc != 4'd0 && !amo_wait) begin
        amo_wait <= 1'b1;
      end else begin
        i_ack    <= 1'b1;
        amo_wait <= 1'b0;
        i_dat_r  <= mem[i_adr[7:2]];
        if (i_tgc == 4'd1) mem[i_adr[7:2]] <= mem[i_adr[7:2]] + i_dat_w;
        else if (i_tgc == 4'd0 && i_we) mem[i_adr[7:2]] <= merge(mem[i_adr[7:2]], i_dat_w, i_sel);
      end
    end else begin
      amo_wait <= 1'b0;
    end
  end

  int          tests;
  int          fails;
  int          cyc;
  logic        act [2];
  logic [31:0] adr [2];
  logic [31:0] wdat [2];
  logic        we [2];
  logic [3:0]  sel [2];
  logic [3:0]  tgc [2];
  int          req_cyc [2];
  int          ack_cyc [2];
  logic [31:0] rdat [2];
  logic [31:0] ref_mem [MEM_WORDS];
  logic        s_a0, s_a1, s_icyc, s_istb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    t0_cyc = act[0]; t0_stb = act[0]; t0_adr = adr[0]; t0_dat_w = wdat[0];
    t0_we  = we[0];  t0_sel = sel[0]; t0_tgc = tgc[0];
    t1_cyc = act[1]; t1_stb = act[1]; t1_adr = adr[1]; t1_dat_w = wdat[1];
    t1_we  = we[1];  t1_sel = sel[1]; t1_tgc = tgc[1];
  endtask

  task automatic start(input int p, input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic [3:0] s, input logic [3:0] g);
    act[p] = 1'b1; adr[p] = a; wdat[p] = d; we[p] = w; sel[p] = s; tgc[p] = g;
    req_cyc[p] = cyc;
  endtask

  // Transaction-level model: apply the finished transfer to ref_mem in ack order.
  task automatic complete(input int p, input logic [31:0] d);
    int idx;
    idx = int'(adr[p][7:2]);
    chk("ack_route", 64'({i_adr, i_tgc, i_we}), 64'({adr[p], tgc[p], we[p]}));
    chk("latency_bound", 64'((cyc - req_cyc[p]) <= 6), 64'(1));
    ack_cyc[p] = cyc;
    rdat[p]    = d;
    if (tgc[p] == 4'd1) begin
      chk("amo_old_value", 64'(d), 64'(ref_mem[idx]));
      ref_mem[idx] = ref_mem[idx] + wdat[p];
    end else if (we[p]) begin
      ref_mem[idx] = merge(ref_mem[idx], wdat[p], sel[p]);
    end else begin
      chk("read_data", 64'(d), 64'(ref_mem[idx]));
    end
    act[p] = 1'b0;
  endtask

  // One clock cycle: drive, sample at negedge, check isolation, retire acked transfers.
  task automatic tick();
    logic        a [2];
    logic [31:0] dr [2];
    logic        own;
    apply();
    @(negedge clock);
    a[0] = t0_ack; a[1] = t1_ack; dr[0] = t0_dat_r; dr[1] = t1_dat_r;
    s_a0 = t0_ack; s_a1 = t1_ack; s_icyc = i_cyc; s_istb = i_stb;
    chk("ack_exclusive", 64'(a[0] & a[1]), 64'(0));
    if (i_stb) begin
      own = (act[0] && i_adr == adr[0] && i_tgc == tgc[0]) ||
            (act[1] && i_adr == adr[1] && i_tgc == tgc[1]);
      chk("stb_owner", 64'(own), 64'(1));
    end
    for (int p = 0; p < 2; p++) begin
      chk("ack_unrequested", 64'(a[p] & ~act[p]), 64'(0));
      if (a[p] && act[p]) complete(p, dr[p]);
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wait_done(input int p, input int budget);
    int n;
    n = 0;
    while (act[p] && n < budget) begin
      tick();
      n++;
    end
    chk("transfer_done", 64'(act[p]), 64'(0));
    act[p] = 1'b0;
  endtask

  task automatic rand_start(input int p);
    int          kind;
    logic [31:0] a;
    kind = $urandom_range(0, 3);
    a    = 32'($urandom_range(0, 15)) << 2;
    case (kind)
      0:       start(p, a, 32'($urandom_range(0, 255)), 1'b0, 4'hF, 4'd1);
      1:       start(p, a, $urandom, 1'b1, 4'($urandom_range(1, 15)), 4'd0);
      default: start(p, a, 32'd0, 1'b0, 4'hF, 4'd0);
    endcase
  endtask

  initial begin
    int c;
    int s [4];
    tests = 0; fails = 0; cyc = 0;
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; adr[p] = '0; wdat[p] = '0; we[p] = 1'b0; sel[p] = '0; tgc[p] = '0;
      req_cyc[p] = 0; ack_cyc[p] = -1; rdat[p] = '0;
    end
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
    reset_n = 1'b0;
    apply();
    @(posedge clock);
    #1;

    // Reset held while both ports request: nothing forwarded, nothing acked.
    start(0, 32'h10, 32'd0, 1'b0, 4'hF, 4'd0);
    start(1, 32'h20, 32'd0, 1'b0, 4'hF, 4'd0);
    repeat (3) begin
      tick();
      chk("rst_i_stb", 64'(s_istb), 64'(0));
      chk("rst_i_cyc", 64'(s_icyc), 64'(0));
      chk("rst_t0_ack", 64'(s_a0), 64'(0));
      chk("rst_t1_ack", 64'(s_a1), 64'(0));
    end
    reset_n = 1'b1;
    c = cyc; req_cyc[0] = cyc; req_cyc[1] = cyc;
    wait_done(0, 10);
    wait_done(1, 10);
    chk("first_grant_p0_ack", 64'(ack_cyc[0]), 64'(c + 2));
    chk("first_grant_p1_ack", 64'(ack_cyc[1]), 64'(c + 4));
    chk("first_read_p0", 64'(rdat[0]), 64'(32'hC0DE_0004));
    chk("first_read_p1", 64'(rdat[1]), 64'(32'hC0DE_0008));

    // Simultaneous plain writes, then cross read-back.
    c = cyc;
    start(0, 32'h0, 32'hAAAA_5555, 1'b1, 4'hF, 4'd0);
    start(1, 32'h4, 32'h1234_5678, 1'b1, 4'hF, 4'd0);
    wait_done(0, 10);
    wait_done(1, 10);
    chk("wr_p0_ack", 64'(ack_cyc[0]), 64'(c + 2));
    chk("wr_p1_ack", 64'(ack_cyc[1]), 64'(c + 4));
    start(0, 32'h4, 32'd0, 1'b0, 4'hF, 4'd0);
    start(1, 32'h0, 32'd0, 1'b0, 4'hF, 4'd0);
    wait_done(0, 10);
    wait_done(1, 10);
    chk("rb_p0", 64'(rdat[0]), 64'(32'h1234_5678));
    chk("rb_p1", 64'(rdat[1]), 64'(32'hAAAA_5555));

    // AMO add on port 0 must complete before port 1's read of the same word.
    start(0, 32'h8, 32'd10, 1'b1, 4'hF, 4'd0);
    wait_done(0, 10);
    c = cyc;
    start(0, 32'h8, 32'd5, 1'b0, 4'hF, 4'd1);
    tick();
    start(1, 32'h8, 32'd0, 1'b0, 4'hF, 4'd0);
    wait_done(0, 10);
    wait_done(1, 10);
    chk("amo_ack", 64'(ack_cyc[0]), 64'(c + 3));
    chk("amo_ret", 64'(rdat[0]), 64'(10));
    chk("amo_then_read_ack", 64'(ack_cyc[1]), 64'(c + 5));
    chk("amo_then_read_val", 64'(rdat[1]), 64'(15));

    // Port 1 streams four reads; port 0 joins during the third.
    for (int k = 0; k < 4; k++) begin
      s[k] = cyc;
      start(1, 32'h10 + 32'(4 * k), 32'd0, 1'b0, 4'hF, 4'd0);
      if (k == 2) begin
        tick();
        start(0, 32'h30, 32'd0, 1'b0, 4'hF, 4'd0);
      end
      wait_done(1, 12);
      chk("stream_latency", 64'(ack_cyc[1] - s[k]), 64'((k == 3) ? 3 : 2));
    end
    chk("stream_p0_ack", 64'(ack_cyc[0]), 64'(s[2] + 4));

    // Abort an AMO after grant: no ack, memory untouched, pointer kept (port 0 wins next tie).
    start(0, 32'h30, 32'd7, 1'b0, 4'hF, 4'd1);
    tick();
    tick();
    chk("abort_granted", 64'(s_icyc), 64'(1));
    act[0] = 1'b0;
    repeat (3) begin
      tick();
      chk("abort_no_ack", 64'(s_a0), 64'(0));
      chk("abort_i_cyc", 64'(s_icyc), 64'(0));
    end
    c = cyc;
    start(0, 32'h30, 32'd0, 1'b0, 4'hF, 4'd0);
    start(1, 32'h34, 32'd0, 1'b0, 4'hF, 4'd0);
    wait_done(0, 10);
    wait_done(1, 10);
    chk("abort_last_kept_p0", 64'(ack_cyc[0]), 64'(c + 2));
    chk("abort_last_kept_p1", 64'(ack_cyc[1]), 64'(c + 4));
    chk("abort_mem_intact", 64'(rdat[0]), 64'(32'hC0DE_000C));

    // Random two-port traffic.
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (act[p] && (cyc - req_cyc[p]) > 20) begin
          chk("stall", 64'(act[p]), 64'(0));
          act[p] = 1'b0;
        end
        if (!act[p] && $urandom_range(0, 2) == 0) rand_start(p);
      end
      tick();
    end
    wait_done(0, 20);
    wait_done(1, 20);

    // Asynchronous reset in the middle of a granted AMO drops the strobe at once.
    start(0, 32'h3C, 32'd1, 1'b0, 4'hF, 4'd1);
    tick();
    tick();
    chk("pre_reset_stb", 64'(i_stb), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("async_rst_i_stb", 64'(i_stb), 64'(0));
    chk("async_rst_i_cyc", 64'(i_cyc), 64'(0));
    chk("async_rst_t0_ack", 64'(t0_ack), 64'(0));
    chk("async_rst_t1_ack", 64'(t1_ack), 64'(0));
    act[0] = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
